fp16_norm_pack: RTL and testbench



---
 rtl/fp16_norm_pack.sv | 144 ++++++++++++++
 tb/tb_fp16_norm_pack.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_norm_pack.sv
// Renormalize, round to nearest even and pack the aligned MAC sum into one FP16 word.
// Define FP16_NORM_SUBNORMAL_EN to produce subnormal results instead of flushing them to zero.
module fp16_norm_pack #(
    parameter int SUM_W     = 27,
    parameter int FRAC_BITS = 20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [5:0]       i_max_exp,
    input  logic [SUM_W-1:0] i_sum,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [15:0]      o_result,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam logic signed [7:0] E_OFS = 8'(SUM_W - 1 - FRAC_BITS);

`ifdef FP16_NORM_SUBNORMAL_EN
    typedef enum logic [2:0] {IDLE, NORM, ROUND, OUT, DENORM} state_t;
`else
    typedef enum logic [2:0] {IDLE, NORM, ROUND, OUT} state_t;
`endif

    state_t            state;
    logic              sign;
    logic [SUM_W-1:0]  mag;
    logic signed [7:0] e;

    logic [SUM_W-1:0]  abs_sum;
    logic [9:0]        frac;
    logic [9:0]        frac_rnd;
    logic              guard_bit;
    logic              sticky;
    logic              inc;
    logic              carry;
    logic signed [7:0] e_rnd;

    // The most negative sum negates to exactly 2^(SUM_W-1), which still fits unsigned.
    assign abs_sum   = i_sum[SUM_W-1] ? (~i_sum + 1'b1) : i_sum;

    assign frac      = mag[SUM_W-2 -: 10];
    assign guard_bit = mag[SUM_W-12];
    assign sticky    = |mag[SUM_W-13:0];
    assign inc       = guard_bit & (sticky | frac[0]);
    assign carry     = (frac == 10'h3FF) & inc;
    assign frac_rnd  = frac + {9'b0, inc};
    assign e_rnd     = carry ? (e + 8'sd1) : e;

    assign o_ready   = (state == IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            o_valid     <= 1'b0;
            o_result    <= 16'h0000;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            sign        <= 1'b0;
            mag         <= '0;
            e           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        sign <= i_sum[SUM_W-1];
                        mag  <= abs_sum;
                        e    <= signed'({2'b00, i_max_exp}) + E_OFS;
                        if (abs_sum == '0) begin
                            o_result    <= 16'h0000;
                            o_overflow  <= 1'b0;
                            o_underflow <= 1'b0;
                            o_valid     <= 1'b1;
                            state       <= OUT;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (!mag[SUM_W-1]) begin
                        mag <= mag << 1;
                        e   <= e - 8'sd1;
                    end else begin
`ifdef FP16_NORM_SUBNORMAL_EN
                        state <= (e <= 8'sd0) ? DENORM : ROUND;
`else
                        state <= ROUND;
`endif
                    end
                end
`ifdef FP16_NORM_SUBNORMAL_EN
                // Right shift toward the minimum exponent, folding lost bits into the sticky LSB.
                DENORM: begin
                    if (e == 8'sd1) begin
                        state <= ROUND;
                    end else begin
                        mag <= {1'b0, mag[SUM_W-1:2], mag[1] | mag[0]};
                        e   <= e + 8'sd1;
                    end
                end
`endif
                ROUND: begin
                    o_valid <= 1'b1;
                    state   <= OUT;
`ifdef FP16_NORM_SUBNORMAL_EN
                    // A clear hidden bit here means DENORM ran; a rounding carry becomes exponent 1.
                    if (!mag[SUM_W-1]) begin
                        o_result    <= {sign, 4'b0000, carry, frac_rnd};
                        o_overflow  <= 1'b0;
                        o_underflow <= ~carry & (frac_rnd == 10'h000);
                    end else
`endif
                    if (e_rnd >= 8'sd31) begin
                        o_result    <= {sign, 5'h1F, 10'h000};
                        o_overflow  <= 1'b1;
                        o_underflow <= 1'b0;
                    end else if (e_rnd <= 8'sd0) begin
                        o_result    <= {sign, 15'h0000};
                        o_overflow  <= 1'b0;
                        o_underflow <= 1'b1;
                    end else begin
                        o_result    <= {sign, e_rnd[4:0], frac_rnd};
                        o_overflow  <= 1'b0;
                        o_underflow <= 1'b0;
                    end
                end
                OUT: begin
                    if (i_ready) begin
                        o_valid     <= 1'b0;
                        o_overflow  <= 1'b0;
                        o_underflow <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_norm_pack.sv
// Self-checking bench for fp16_norm_pack: directed corner cases plus random sums against a numeric FP16 model.
// Honours FP16_NORM_SUBNORMAL_EN the same way the design does.
module tb_fp16_norm_pack;

    localparam int SUM_W     = 27;
    localparam int FRAC_BITS = 20;

    logic             i_clk;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [5:0]       i_max_exp;
    logic [SUM_W-1:0] i_sum;
    logic             o_valid;
    logic             i_ready;
    logic [15:0]      o_result;
    logic             o_overflow;
    logic             o_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    fp16_norm_pack #(.SUM_W(SUM_W), .FRAC_BITS(FRAC_BITS)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_max_exp  (i_max_exp),
        .i_sum      (i_sum),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Numeric model: locate the leading one, scale to 11 significant bits, round half to even.
    function automatic void ref_model(input int me, input logic [SUM_W-1:0] s,
                                      output logic [15:0] r, output logic ov, output logic un);
        longint sv, m, q, rem, half;
        int p, eb, sh;
        logic sg;
        sv = longint'($signed(s));
        sg = (sv < 0);
        m  = sg ? -sv : sv;
        r  = 16'h0000; ov = 1'b0; un = 1'b0;
        if (m == 0) return;
        p = 0;
        for (int i = 0; i < SUM_W; i++) if (m[i]) p = i;
        eb = p + me - FRAC_BITS;
        sh = p - 10;
`ifdef FP16_NORM_SUBNORMAL_EN
        if (eb <= 0) sh = sh + (1 - eb);
`endif
        if (sh > 0) begin
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end else begin
            q = m << (-sh);
        end
`ifdef FP16_NORM_SUBNORMAL_EN
        if (eb <= 0) begin
            r  = {sg, 4'b0000, q[10], q[9:0]};
            un = (q == 0);
            return;
        end
`endif
        if (q == 2048) begin
            q = 1024;
            eb++;
        end
        if (eb >= 31) begin
            r = {sg, 5'h1F, 10'h000}; ov = 1'b1;
        end else if (eb <= 0) begin
            r = {sg, 15'h0000}; un = 1'b1;
        end else begin
            r = {sg, 5'(eb), q[9:0]};
        end
    endfunction

    // Present one operand, wait for acceptance, then count edges until o_valid rises.
    task automatic apply_stimulus(input logic [5:0] me, input logic [SUM_W-1:0] s, output int lat);
        int wait_cnt = 0;
        @(negedge i_clk);
        i_max_exp = me;
        i_sum     = s;
        i_valid   = 1'b1;
        while (!o_ready && wait_cnt < 200) begin
            @(negedge i_clk);
            wait_cnt++;
        end
        check("accept_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(negedge i_clk);
            lat++;
        end
        check("result_valid", 32'(o_valid), 32'd1);
    endtask

    task automatic check_output(input string tag, input logic [15:0] r, input logic ov, input logic un);
        check({tag, "_result"}, 32'(o_result), 32'(r));
        check({tag, "_ovf"}, 32'(o_overflow), 32'(ov));
        check({tag, "_unf"}, 32'(o_underflow), 32'(un));
    endtask

    task automatic consume(input int hold);
        repeat (hold) @(negedge i_clk);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [15:0] r, held;
        logic ov, un;
        logic [5:0] me;
        logic [SUM_W-1:0] s;
        longint val;

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_max_exp = '0; i_sum = '0;
        repeat (3) @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check_output("rst", 16'h0000, 1'b0, 1'b0);
        i_rst = 1'b0;

        apply_stimulus(6'd15, 27'(1 << 20), lat);
        check("one_latency", 32'(lat), 32'd8);
        check_output("one", 16'h3C00, 1'b0, 1'b0);
        consume(0);
        check("one_drop", 32'(o_valid), 32'd0);

        apply_stimulus(6'd15, 27'(-(3 << 19)), lat);
        check_output("neg1p5", 16'hBE00, 1'b0, 1'b0);
        consume(1);

        apply_stimulus(6'd15, 27'((1 << 20) + (1 << 9)), lat);
        check_output("rne_tie", 16'h3C00, 1'b0, 1'b0);
        consume(0);

        apply_stimulus(6'd15, 27'((1 << 20) + (1 << 9) + 1), lat);
        check_output("rne_up", 16'h3C01, 1'b0, 1'b0);
        consume(0);

        apply_stimulus(6'd40, 27'(1 << 20), lat);
        check_output("ovf", 16'h7C00, 1'b1, 1'b0);
        consume(0);

        apply_stimulus(6'd0, 27'(1 << 20), lat);
`ifdef FP16_NORM_SUBNORMAL_EN
        check_output("tiny", 16'h0200, 1'b0, 1'b0);
`else
        check_output("tiny", 16'h0000, 1'b0, 1'b1);
`endif
        consume(0);

        apply_stimulus(6'd37, 27'd0, lat);
        check("zero_latency", 32'(lat), 32'd0);
        check_output("zero", 16'h0000, 1'b0, 1'b0);
        consume(0);

        // Backpressure: output must hold while downstream stalls.
        apply_stimulus(6'd15, 27'(3 << 19), lat);
        held = o_result;
        check("bp_first", 32'(held), 32'h3E00);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_result", 32'(o_result), 32'h3E00);
            check("bp_ready", 32'(o_ready), 32'd0);
        end
        consume(0);

        // Asynchronous reset in the middle of a long normalization.
        @(negedge i_clk);
        i_max_exp = 6'd15; i_sum = 27'd1; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check("norm_busy", 32'(o_ready), 32'd0);
        #2 i_rst = 1'b1;
        #1;
        check("midrst_ready", 32'(o_ready), 32'd1);
        check("midrst_valid", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Asynchronous reset while a result is being presented.
        apply_stimulus(6'd15, 27'(1 << 20), lat);
        #2 i_rst = 1'b1;
        #1;
        check("outrst_valid", 32'(o_valid), 32'd0);
        check("outrst_result", 32'(o_result), 32'h0000);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int n = 0; n < 40; n++) begin
            me  = 6'($urandom_range(0, 45));
            val = longint'($urandom & ((32'd1 << $urandom_range(1, 26)) - 1));
            if ($urandom_range(0, 1) == 1) val = -val;
            s = 27'(val);
            ref_model(int'(me), s, r, ov, un);
            apply_stimulus(me, s, lat);
            check_output("rand", r, ov, un);
            consume($urandom_range(0, 3));
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
